// File: rtl/div_sequencer.sv
// div_sequencer: iterative restoring divider, one quotient bit per clock.
// Latency: WIDTH clocks from the ctrl_DIV capture edge to data_resultRDY; divide-by-zero completes on the capture edge.
// Build option DIV_SIGNED_EN: two's complement operands with sign correction and overflow flag; default build is unsigned.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [CNT_W-1:0] n_iter
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   r_q, q_q, b_q;
  logic               neg_quo_q, neg_rem_q, ovf_q;
  logic [WIDTH-1:0]   res_q, rem_q;
  logic               exc_q;

  logic               b_zero, last_iter;
  logic               a_neg, b_neg, ovf_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     r_sh, trial;
  logic [WIDTH-1:0]   r_nx, q_nx, fin_q, fin_r;

  assign b_zero    = (data_operandB == '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Operand magnitudes and sign/overflow flags taken at capture
  always_comb begin
    a_neg  = 1'b0;
    b_neg  = 1'b0;
    ovf_in = 1'b0;
    a_mag  = data_operandA;
    b_mag  = data_operandB;
`ifdef DIV_SIGNED_EN
    a_neg  = data_operandA[WIDTH-1];
    b_neg  = data_operandB[WIDTH-1];
    a_mag  = a_neg ? (~data_operandA + 1'b1) : data_operandA;
    b_mag  = b_neg ? (~data_operandB + 1'b1) : data_operandB;
    // Most-negative / -1: the magnitude quotient already equals most-negative
    ovf_in = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
`endif
  end

  // One restoring step: shift {R,Q}, trial-subtract |B| in WIDTH+1 bits, keep if non-negative
  always_comb begin
    r_sh  = {r_q, q_q[WIDTH-1]};
    trial = r_sh - {1'b0, b_q};
    r_nx  = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_nx  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    fin_q = neg_quo_q ? (~q_nx + 1'b1) : q_nx;
    fin_r = neg_rem_q ? (~r_nx + 1'b1) : r_nx;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a start pulse overrides whatever the current state would do
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_RUN:   state_d = last_iter ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ctrl_DIV) state_d = b_zero ? S_DONE : S_RUN;
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy           = (state_q == S_RUN);
    data_resultRDY = (state_q == S_DONE);
  end

  // Datapath: capture on start, iterate in RUN, write results on the DONE-entry edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      rem_q     <= '0;
      exc_q     <= 1'b0;
    end else if (ctrl_DIV) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= a_mag;
      b_q       <= b_mag;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      ovf_q     <= ovf_in;
      if (b_zero) begin
        res_q <= '0;
        rem_q <= '0;
        exc_q <= 1'b1;
      end
    end else if (state_q == S_RUN) begin
      r_q <= r_nx;
      q_q <= q_nx;
      if (last_iter) begin
        // Counter holds at WIDTH-1 so it never wraps within an operation
        res_q <= fin_q;
        rem_q <= fin_r;
        exc_q <= ovf_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign data_result    = res_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign n_iter         = cnt_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer at WIDTH=32; expectations follow DIV_SIGNED_EN.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result, data_remainder;
  logic        data_exception, data_resultRDY, busy;
  logic [4:0]  n_iter;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .n_iter         (n_iter)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and check latency, busy/n_iter, results and pulse width
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_e, input int exp_lat);
    int cyc;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV      = 1'b0;
    if (exp_lat > 0) begin
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      chk({tag, "_niter_start"}, 32'(n_iter), 32'd0);
    end
    cyc = 0;
    while (!data_resultRDY && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_quot"}, data_result, exp_q);
    chk({tag, "_rem"}, data_remainder, exp_r);
    chk({tag, "_exc"}, 32'(data_exception), 32'(exp_e));
    if (exp_lat > 0) begin
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_niter_done"}, 32'(n_iter), 32'd31);
    end
    tick();
    chk({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'd0);
    chk({tag, "_quot_hold"}, data_result, exp_q);
  endtask

  initial begin
    int seen;
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick();
    tick();
    chk("rst_quot", data_result, 32'd0);
    chk("rst_rem", data_remainder, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_niter", 32'(n_iter), 32'd0);
    reset_n = 1'b1;
    tick();

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);

    // Restart: new start mid-run aborts; previous results stay visible meanwhile
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    chk("restart_hold_quot", data_result, 32'd14);
    chk("restart_hold_rem", data_remainder, 32'd2);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (data_resultRDY) seen++;
    end
    chk("restart_no_rdy", 32'(seen), 32'd0);
    run_div("restart_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

`ifdef DIV_SIGNED_EN
    run_div("neg100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 32);
`else
    run_div("neg100_7", 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 32);
`endif

    run_div("div0", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 0);

`ifdef DIV_SIGNED_EN
    run_div("minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 32);
`else
    run_div("minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
`endif

    // Reset at cycle 15 of a run, with a start pulse on the same edge
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    tick();
    reset_n  = 1'b1;
    ctrl_DIV = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_niter", 32'(n_iter), 32'd0);
    chk("midrst_quot", data_result, 32'd0);
    chk("midrst_rem", data_remainder, 32'd0);
    chk("midrst_exc", 32'(data_exception), 32'd0);
    chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY || busy) seen++;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
